// File: rtl/lvds_deser_pkg.sv
// lvds_deser_pkg: shared FSM states and the bit-order helper for the LVDS deserializer
package lvds_deser_pkg;
  typedef enum logic [1:0] {ST_HUNT, ST_VERIFY, ST_LOCKED} state_t;
  localparam int MAX_W = 64;
  function automatic logic [MAX_W-1:0] bit_rev(input logic [MAX_W-1:0] x, input int w);
    logic [MAX_W-1:0] r;
    for (int i = 0; i < MAX_W; i++) r[i] = x[MAX_W-1-i];
    return r >> (MAX_W - w);
  endfunction
endpackage

// File: rtl/lvds_lane_shifter.sv
// lvds_lane_shifter: one serial lane; o_cand is the word the lane holds after this cycle's bit
module lvds_lane_shifter
  import lvds_deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_cand
);
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_nxt;
  assign w_nxt  = {r_sr[WIDTH-2:0], i_bit};
  assign o_cand = MSB_FIRST ? w_nxt : WIDTH'(bit_rev(MAX_W'(w_nxt), WIDTH));
  // Register always fills from the LSB; LSB-first lanes present the bit-reversed view
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_sr <= '0;
    else r_sr <= w_nxt;
endmodule

// File: rtl/lvds_deser_align.sv
// lvds_deser_align: multi-lane deserializer that hunts, verifies and locks onto a lane-0 sync word
module lvds_deser_align
  import lvds_deser_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               LANES     = 1,
  parameter bit               MSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] SYNC_WORD = 8'hF0,
  parameter int               FRAME_LEN = 4,
  parameter int               LOCK_CNT  = 3,
  parameter int               MISS_MAX  = 2
) (
  input  logic                   lvds_clk,
  input  logic                   rst_n,
  input  logic [LANES-1:0]       lvds_in,
  output logic [LANES*WIDTH-1:0] lvds_out,
  output logic                   out_valid,
  output logic                   frame_start,
  output logic                   locked,
  output logic                   sync_err
);
  localparam int BW = $clog2(WIDTH);
  localparam int FW = $clog2(FRAME_LEN);
  localparam int HW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(MISS_MAX + 1);
  state_t r_state, w_state;
  logic [BW-1:0] r_bit, w_bit;
  logic [FW-1:0] r_word, w_word;
  logic [HW-1:0] r_hit, w_hit;
  logic [MW-1:0] r_miss, w_miss;
  logic [LANES*WIDTH-1:0] r_out, w_out, w_cand;
  logic r_valid, w_valid, r_fs, w_fs, r_err, w_err;
  logic w_bnd, w_slot, w_match;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lvds_lane_shifter #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_lane (
      .i_clk  (lvds_clk),
      .i_rst_n(rst_n),
      .i_bit  (lvds_in[g]),
      .o_cand (w_cand[g*WIDTH +: WIDTH])
    );
  end
  assign w_bnd   = r_bit == BW'(WIDTH - 1);
  assign w_slot  = w_bnd && r_word == '0;
  assign w_match = w_cand[WIDTH-1:0] == SYNC_WORD;
  // Next state, counters and output strobes; a HUNT match is treated as the sync word's boundary
  always_comb begin
    w_state = r_state;
    w_bit   = w_bnd ? '0 : r_bit + 1'b1;
    w_word  = w_bnd ? (r_word == FW'(FRAME_LEN - 1) ? '0 : r_word + 1'b1) : r_word;
    w_hit   = r_hit;
    w_miss  = r_miss;
    w_out   = r_out;
    w_valid = 1'b0;
    w_fs    = 1'b0;
    w_err   = 1'b0;
    case (r_state)
      ST_HUNT: if (w_match) begin
        w_state = LOCK_CNT <= 1 ? ST_LOCKED : ST_VERIFY;
        w_bit   = '0;
        w_word  = FW'(1);
        w_hit   = HW'(1);
        w_miss  = '0;
      end
      ST_VERIFY: if (w_slot) begin
        if (!w_match) begin
          w_state = ST_HUNT;
          w_hit   = '0;
        end else begin
          w_hit = r_hit + 1'b1;
          if (w_hit == HW'(LOCK_CNT)) begin
            w_state = ST_LOCKED;
            w_miss  = '0;
          end
        end
      end
      ST_LOCKED: if (w_bnd) begin
        w_out   = w_cand;
        w_valid = 1'b1;
        if (w_slot) begin
          if (w_match) begin
            w_fs   = 1'b1;
            w_miss = '0;
          end else begin
            w_err  = 1'b1;
            w_miss = r_miss + 1'b1;
            if (w_miss == MW'(MISS_MAX)) begin
              w_state = ST_HUNT;
              w_hit   = '0;
            end
          end
        end
      end
      default: w_state = ST_HUNT;
    endcase
  end
  // Alignment state register
  always_ff @(posedge lvds_clk or negedge rst_n)
    if (!rst_n) r_state <= ST_HUNT;
    else r_state <= w_state;
  // Bit/word/hit/miss counters and registered outputs
  always_ff @(posedge lvds_clk or negedge rst_n)
    if (!rst_n) begin
      r_bit   <= '0;
      r_word  <= '0;
      r_hit   <= '0;
      r_miss  <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_fs    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_bit   <= w_bit;
      r_word  <= w_word;
      r_hit   <= w_hit;
      r_miss  <= w_miss;
      r_out   <= w_out;
      r_valid <= w_valid;
      r_fs    <= w_fs;
      r_err   <= w_err;
    end
  assign lvds_out    = r_out;
  assign out_valid   = r_valid;
  assign frame_start = r_fs;
  assign sync_err    = r_err;
  assign locked      = r_state == ST_LOCKED;
endmodule
